// File: rtl/bitcoin_nonce_scheduler_pkg.sv
// Shared types and defaults for the nonce scheduler: scheduler and per-core states.
package bitcoin_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} sched_state_t;
    typedef enum logic [1:0] {FREE, RUNNING, PENDING} core_state_t;

    localparam int NONCE_W        = 32;
    localparam int DEF_NUM_CORES  = 4;
    localparam int DEF_NUM_NONCES = 16;

endpackage

// File: rtl/bitcoin_nonce_scheduler_rr_arbiter.sv
// Round-robin arbiter: lowest requester at or after the pointer wins; the pointer
// moves past the winner only when the consumer takes the grant (advance).
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] candIdx;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        candIdx   = '0;
        for (int i = 0; i < N; i++) begin
            candIdx = IDX_W'((int'(ptr_q) + i) % N);
            if (!found && req[candIdx]) begin
                found            = 1'b1;
                grant[candIdx]   = 1'b1;
                grant_idx        = candIdx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (advance && found) begin
            ptr_q <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/bitcoin_nonce_scheduler.sv
// Nonce dispatcher and h0 writeback arbiter for a multi-core hash engine.
// Define SCHED_PERF_EN to add the perf_cycles job-length counter output.
module bitcoin_nonce_scheduler
    import bitcoin_pkg::*;
#(
    parameter int NUM_CORES  = DEF_NUM_CORES,
    parameter int NUM_NONCES = DEF_NUM_NONCES,
    parameter int ADDR_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       output_addr,
    output logic                    done,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [NONCE_W-1:0]      core_nonce,
    input  logic [NUM_CORES-1:0]    core_done,
    input  logic [NUM_CORES*32-1:0] core_h0,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [31:0]             mem_write_data
`ifdef SCHED_PERF_EN
    ,
    output logic [31:0]             perf_cycles
`endif
);

    localparam int                 IDX_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [NONCE_W-1:0] NONCE_LIMIT = NONCE_W'(NUM_NONCES);

    sched_state_t        state_q, state_d;
    core_state_t         coreState_q [NUM_CORES];
    logic [31:0]         coreH0_q    [NUM_CORES];
    logic [ADDR_W-1:0]   coreTag_q   [NUM_CORES];
    logic [NONCE_W-1:0]  nextNonce_q, written_q;
    logic [ADDR_W-1:0]   baseAddr_q, memAddr_q;
    logic [31:0]         memData_q;
    logic                memWe_q;
    logic [NUM_CORES-1:0] wbOneHot_q;

    logic [NUM_CORES-1:0] dispReq, wbReq, dispGrant, wbGrant;
    logic [IDX_W-1:0]     dispIdx, wbIdx;
    logic                 dispEnable, dispFire, wbFire;
    logic [31:0]          wbData;

    // A core finishing this cycle competes for writeback directly, and a core whose
    // write is on the bus this cycle is held back from dispatch for one more cycle.
    always_comb begin
        dispReq = '0;
        wbReq   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            dispReq[i] = (coreState_q[i] == FREE) && !wbOneHot_q[i];
            wbReq[i]   = (coreState_q[i] == PENDING) ||
                         ((coreState_q[i] == RUNNING) && core_done[i]);
        end
    end

    assign dispEnable = reset_n && (state_q == RUN) && (nextNonce_q < NONCE_LIMIT);
    assign dispFire   = dispEnable && (|dispReq);
    assign wbFire     = |wbReq;
    assign wbData     = (coreState_q[wbIdx] == PENDING) ? coreH0_q[wbIdx]
                                                        : core_h0[32*int'(wbIdx) +: 32];

    rr_arbiter #(.N(NUM_CORES)) u_dispArb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (dispReq),
        .advance   (dispEnable),
        .grant     (dispGrant),
        .grant_idx (dispIdx)
    );

    rr_arbiter #(.N(NUM_CORES)) u_wbArb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (wbReq),
        .advance   (1'b1),
        .grant     (wbGrant),
        .grant_idx (wbIdx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (written_q == NONCE_LIMIT) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign done           = (state_q == FINISH);
    assign core_start     = dispFire ? dispGrant : '0;
    assign core_nonce     = dispFire ? nextNonce_q : '0;
    assign mem_we         = memWe_q;
    assign mem_addr       = memAddr_q;
    assign mem_write_data = memData_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            nextNonce_q <= '0;
            written_q   <= '0;
            baseAddr_q  <= '0;
            memWe_q     <= 1'b0;
            memAddr_q   <= '0;
            memData_q   <= '0;
            wbOneHot_q  <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                coreState_q[i] <= FREE;
                coreH0_q[i]    <= '0;
                coreTag_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            memWe_q    <= wbFire;
            wbOneHot_q <= wbFire ? wbGrant : '0;
            if (wbFire) begin
                memAddr_q <= baseAddr_q + coreTag_q[wbIdx];
                memData_q <= wbData;
            end
            if (state_q == IDLE && start) begin
                baseAddr_q  <= output_addr;
                nextNonce_q <= '0;
                written_q   <= '0;
            end else begin
                if (dispFire) nextNonce_q <= nextNonce_q + 1'b1;
                if (wbFire)   written_q   <= written_q + 1'b1;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (dispFire && int'(dispIdx) == i) begin
                    coreState_q[i] <= RUNNING;
                    coreTag_q[i]   <= nextNonce_q[ADDR_W-1:0];
                end else if (wbFire && int'(wbIdx) == i) begin
                    coreState_q[i] <= FREE;
                end else if (coreState_q[i] == RUNNING && core_done[i]) begin
                    coreState_q[i] <= PENDING;
                    coreH0_q[i]    <= core_h0[32*i +: 32];
                end
            end
        end
    end

`ifdef SCHED_PERF_EN
    // Counts the accept cycle plus every RUN/FINISH cycle, then holds through IDLE.
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_q <= '0;
        end else if (state_q == IDLE && start) begin
            perf_q <= 32'd1;
        end else if (state_q != IDLE && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule
